// File: rtl/render_pkg.sv
// render_pkg: shared board geometry, cell/FSM types and colour expansion for the board renderer.
package render_pkg;
    localparam int B_COLS    = 10;
    localparam int B_ROWS    = 20;
    localparam int SQ_SIZE   = 21;
    localparam int B_LEFT    = 213;
    localparam int CELL_BITS = 16;
    localparam int V_LAST    = 479;
    localparam logic [23:0] BG_RGB = 24'h00FC39;

    typedef logic [CELL_BITS-1:0] cell_t;
    typedef enum logic [1:0] {IDLE, LOAD, READY} fsm_t;

    function automatic logic [23:0] expand444(input logic [11:0] c);
        return {c[11:8], 4'h0, c[7:4], 4'h0, c[3:0], 4'h0};
    endfunction
endpackage

// File: rtl/row_line_buffer.sv
// row_line_buffer: two banks of one board row each; writes go to a chosen bank, reads come from the front bank.
module row_line_buffer #(
    parameter int COLS = 10,
    parameter int W    = 16,
    parameter int IW   = 4
) (
    input  logic          Clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [IW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic [IW-1:0] rd_idx,
    input  logic          toggle,
    output logic          front,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [2][COLS];

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            front <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < COLS; i++)
                    mem[b][i] <= '0;
        end else begin
            front <= front ^ toggle;
            if (we) mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[front][rd_idx];
endmodule

// File: rtl/board_row_renderer.sv
// board_row_renderer: prefetches board rows into a double-buffered line store and emits registered RGB.
// Define GRID_OUTLINE_EN to draw black outlines around non-empty cells.
module board_row_renderer
    import render_pkg::*;
#(
    parameter int BOARD_COLS  = B_COLS,
    parameter int BOARD_ROWS  = B_ROWS,
    parameter int SQUARE_SIZE = SQ_SIZE,
    parameter int LEFT_EDGE   = B_LEFT,
    parameter int CELL_W      = CELL_BITS,
    parameter int LAST_LINE   = V_LAST,
    parameter logic [23:0] BG_COLOR = BG_RGB
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              hs,
    output logic              row_req,
    output logic [7:0]        row_idx,
    input  logic              cell_valid,
    input  logic [CELL_W-1:0] cell_data,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              underflow
);
    localparam int CW = BOARD_COLS > 1 ? $clog2(BOARD_COLS) : 1;
    localparam int SW = $clog2(SQUARE_SIZE);
    localparam logic [9:0] X0 = 10'(LEFT_EDGE);
    localparam logic [9:0] X1 = 10'(LEFT_EDGE + BOARD_COLS * SQUARE_SIZE);
    localparam logic [9:0] Y1 = 10'(BOARD_ROWS * SQUARE_SIZE);
    localparam logic [9:0] YL = 10'(LAST_LINE);
    localparam logic [9:0] ROWS = 10'(BOARD_ROWS);
    localparam logic [SW-1:0] SQ_LAST = SW'(SQUARE_SIZE - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(BOARD_COLS - 1);

    fsm_t state_q, state_d;
    logic [CW-1:0] col_q, col_d, cx_q, cur_cx;
    logic [SW-1:0] sub_q, xo_q, cur_xo;
    logic [9:0] row_q;
    logic [7:0] idx_d;
    logic uf_d, hs_q, x0_q, hs_fall, last_line, trigger, swap_pt, toggle, front, in_board;
    logic [CELL_W-1:0] cell_word;
    logic [23:0] cell_rgb, pix;
    logic unused_bits;

    // sub_q/row_q hold DrawY % SQUARE_SIZE and DrawY / SQUARE_SIZE of the line after the last hs edge
    assign hs_fall   = hs_q & ~hs;
    assign last_line = DrawY == YL;
    assign trigger   = hs_fall && (last_line || (sub_q == SQ_LAST && row_q + 10'd1 < ROWS));
    assign swap_pt   = DrawX == 10'd0 && !x0_q && sub_q == '0;
    assign row_req   = state_q == LOAD;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        idx_d   = row_idx;
        uf_d    = underflow;
        toggle  = 1'b0;
        case (state_q)
            IDLE: if (trigger) begin
                state_d = LOAD;
                col_d   = '0;
                idx_d   = last_line ? 8'd0 : 8'(row_q + 10'd1);
            end
            LOAD: begin
                uf_d = underflow | trigger | swap_pt;
                if (cell_valid) begin
                    col_d   = col_q + 1'b1;
                    state_d = col_q == COL_LAST ? READY : LOAD;
                end
            end
            READY: begin
                uf_d    = underflow | trigger;
                toggle  = swap_pt;
                state_d = swap_pt ? IDLE : READY;
            end
            default: state_d = IDLE;
        endcase
    end

    // x-in-cell counter restarts at the left board edge and assumes DrawX steps by one per clock
    assign cur_cx   = DrawX == X0 ? '0 : cx_q;
    assign cur_xo   = DrawX == X0 ? '0 : xo_q;
    assign in_board = DrawX >= X0 && DrawX < X1 && DrawY < Y1;

`ifdef GRID_OUTLINE_EN
    logic on_edge;
    assign on_edge  = cur_xo == '0 || cur_xo == SQ_LAST || sub_q == '0 || sub_q == SQ_LAST;
    assign cell_rgb = (on_edge && |cell_word[11:0]) ? 24'h000000 : expand444(cell_word[11:0]);
`else
    assign cell_rgb = expand444(cell_word[11:0]);
`endif
    assign pix         = in_board ? cell_rgb : BG_COLOR;
    assign unused_bits = ^cell_word;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_idx   <= 8'd0;
            underflow <= 1'b0;
            hs_q      <= 1'b0;
            x0_q      <= 1'b0;
            sub_q     <= '0;
            row_q     <= 10'd0;
            cx_q      <= '0;
            xo_q      <= '0;
            Red       <= 8'd0;
            Green     <= 8'd0;
            Blue      <= 8'd0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_idx   <= idx_d;
            underflow <= uf_d;
            hs_q      <= hs;
            x0_q      <= DrawX == 10'd0;
            if (hs_fall) begin
                sub_q <= (last_line || sub_q == SQ_LAST) ? '0 : sub_q + 1'b1;
                row_q <= last_line ? 10'd0 : (sub_q == SQ_LAST ? row_q + 10'd1 : row_q);
            end
            cx_q <= cur_xo == SQ_LAST ? cur_cx + 1'b1 : cur_cx;
            xo_q <= cur_xo == SQ_LAST ? '0 : cur_xo + 1'b1;
            {Red, Green, Blue} <= pix;
        end
    end

    row_line_buffer #(.COLS(BOARD_COLS), .W(CELL_W), .IW(CW)) u_buf (
        .Clk     (Clk),
        .reset_n (reset_n),
        .we      (state_q == LOAD && cell_valid),
        .wr_bank (~front),
        .wr_idx  (col_q),
        .wr_data (cell_data),
        .rd_idx  (cur_cx),
        .toggle  (toggle),
        .front   (front),
        .rd_data (cell_word)
    );
endmodule

// File: tb/tb_board_row_renderer.sv
// tb_board_row_renderer: directed line-by-line scan of board_row_renderer with a row feeder and pixel checks.
module tb_board_row_renderer;
    logic Clk = 1'b0;
    logic reset_n;
    logic [9:0] DrawX, DrawY;
    logic hs, row_req, cell_valid, underflow;
    logic [7:0] row_idx, Red, Green, Blue;
    logic [15:0] cell_data;
    int errors = 0, checks = 0, fcnt = 0, feed_max = 10;
    bit feed_en = 1'b0;

    board_row_renderer dut (
        .Clk(Clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .hs(hs),
        .row_req(row_req), .row_idx(row_idx), .cell_valid(cell_valid), .cell_data(cell_data),
        .Red(Red), .Green(Green), .Blue(Blue), .underflow(underflow)
    );

    initial forever #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // upper nibble is junk the renderer must ignore; row 3 is solid red
    function automatic logic [15:0] cell_val(input int r, input int c);
        logic [15:0] v;
        v = {4'hA, 4'(r), 4'(c), 4'h1};
        return r == 3 ? 16'h0F00 : v;
    endfunction

    function automatic logic [23:0] px(input int x, input int y, input int r);
        logic [15:0] v;
        if (x < 213 || x >= 423 || y >= 420) return 24'h00FC39;
        v = cell_val(r, (x - 213) / 21);
`ifdef GRID_OUTLINE_EN
        if (v[11:0] != 12'h0 && ((x - 213) % 21 == 0 || (x - 213) % 21 == 20 || y % 21 == 0 || y % 21 == 20))
            return 24'h000000;
`endif
        return {v[11:8], 4'h0, v[7:4], 4'h0, v[3:0], 4'h0};
    endfunction

    // one clock: feed the next cell while a row is requested, then advance to the next negedge
    task automatic cyc();
        if (!row_req) fcnt = 0;
        cell_valid = feed_en && row_req && fcnt < feed_max;
        cell_data  = cell_val(int'(row_idx), fcnt);
        if (cell_valid) fcnt++;
        @(negedge Clk);
    endtask

    task automatic line(input int y, input int r);
        DrawY = 10'(y);
        DrawX = 10'd0;
        cyc();
        if (r >= 0) begin
            check($sformatf("px y%0d x0", y), 32'({Red, Green, Blue}), 32'(px(0, y, r)));
            for (int x = 1; x <= 424; x++) begin
                DrawX = 10'(x);
                cyc();
                if (x inside {100, 212, 213, 233, 234, 254, 300, 422, 423})
                    check($sformatf("px y%0d x%0d", y, x), 32'({Red, Green, Blue}), 32'(px(x, y, r)));
            end
        end
        DrawX = 10'd700;
        hs = 1'b0;
        cyc();
        hs = 1'b1;
        repeat (14) cyc();
    endtask

    initial begin
        reset_n = 1'b0; hs = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
        cell_valid = 1'b0; cell_data = 16'h0;
        repeat (3) @(negedge Clk);
        check("reset rgb", 32'({Red, Green, Blue}), 32'h0);
        check("reset req", 32'(row_req), 32'd0);
        check("reset idx", 32'(row_idx), 32'd0);
        check("reset uf", 32'(underflow), 32'd0);
        reset_n = 1'b1;
        cyc(); cyc();
        // reset in the middle of a row load
        feed_en = 1'b1; feed_max = 4;
        DrawY = 10'd479; DrawX = 10'd700; hs = 1'b0;
        cyc();
        hs = 1'b1;
        repeat (8) cyc();
        check("midload req", 32'(row_req), 32'd1);
        check("midload rgb", 32'({Red, Green, Blue}), 32'h00FC39);
        reset_n = 1'b0;
        #1;
        check("rst req", 32'(row_req), 32'd0);
        check("rst rgb", 32'({Red, Green, Blue}), 32'h0);
        check("rst uf", 32'(underflow), 32'd0);
        feed_en = 1'b0; feed_max = 10;
        cyc();
        reset_n = 1'b1;
        cyc(); cyc();
        // last-line trigger fetches row 0; row_req drops after the tenth cell
        DrawY = 10'd479; hs = 1'b0;
        cyc();
        hs = 1'b1;
        check("last req", 32'(row_req), 32'd1);
        check("last idx", 32'(row_idx), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) check("req before 10th", 32'(row_req), 32'd1);
            cell_valid = 1'b1;
            cell_data  = cell_val(0, i);
            @(negedge Clk);
        end
        cell_valid = 1'b0;
        check("req after 10th", 32'(row_req), 32'd0);
        feed_en = 1'b1;
        for (int y = 0; y < 480; y++)
            line(y, y inside {0, 20, 21, 63, 470} ? y / 21 : -1);
        check("frame1 uf", 32'(underflow), 32'd0);
        // starve row 2 past its swap point
        for (int y = 0; y < 64; y++) begin
            if (y == 41) begin
                check("uf before starve", 32'(underflow), 32'd0);
                feed_en = 1'b0;
            end
            line(y, y == 42 || y == 62 ? 1 : (y == 63 ? 2 : -1));
            if (y == 42) begin
                check("uf after starve", 32'(underflow), 32'd1);
                feed_en = 1'b1;
            end
        end
        check("late trigger ignored", 32'(row_req), 32'd0);
        check("uf sticky", 32'(underflow), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
